// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, default reset PC and the buffered fetch entry type
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count; DEPTH must be a power of two
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != FULL || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, imem request/response tracking and decode queues; FETCH_MISALIGN_CHECK_EN halts on misaligned redirect
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_addr,
  output logic            fetch_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 16;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [XLEN-1:0] fetch_pc, addr_head;
  logic [ILEN-1:0] data_head;
  logic [CW-1:0] a_cnt, d_cnt, pending;
  logic [DW-1:0] disc;
  logic grant, push_d, pop, misalign, err_q;
  fetch_entry_t head;
  assign pending = a_cnt - d_cnt;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = redirect_valid && redirect_pc[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif
  assign fetch_err = err_q;
  assign imem_req = rst_n && a_cnt != FULL && !redirect_valid && !err_q;
  assign imem_addr = fetch_pc;
  assign grant = imem_req && imem_gnt;
  assign push_d = imem_rvalid && !redirect_valid && disc == '0 && pending != '0;
  assign inst_valid = d_cnt != '0;
  assign pop = inst_valid && inst_ready && !redirect_valid;
  assign head = '{addr: addr_head, inst: data_head};
  assign inst = inst_valid ? head.inst : '0;
  assign inst_addr = inst_valid ? head.addr : '0;
  // disc counts responses still owed to fetches flushed by earlier redirects
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      disc <= '0;
      err_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= misalign ? redirect_pc : {redirect_pc[XLEN-1:2], 2'b00};
      disc <= disc + DW'(pending) - DW'(imem_rvalid && (disc != '0 || pending != '0));
      err_q <= err_q | misalign;
    end else begin
      if (grant) fetch_pc <= fetch_pc + XLEN'(4);
      if (imem_rvalid && disc != '0) disc <= disc - DW'(1);
    end
  end
  fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk, .rst_n, .flush(redirect_valid), .push(grant), .pop,
    .wdata(fetch_pc), .rdata(addr_head), .count(a_cnt)
  );
  fetch_fifo #(.W(ILEN), .DEPTH(DEPTH)) u_data_q (
    .clk, .rst_n, .flush(redirect_valid), .push(push_d), .pop,
    .wdata(imem_rdata), .rdata(data_head), .count(d_cnt)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and random stimulus against an in-order memory and fetch-stream reference model
module tb_inst_fetch;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] addr;
    int due;
    bit stale;
  } req_t;
  logic clk = 0, rst_n = 0, imem_gnt = 0, imem_rvalid = 0, redirect_valid = 0, inst_ready = 0;
  logic imem_req, inst_valid, fetch_err;
  logic [31:0] imem_addr, inst, inst_addr;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0, lat = 1, entries = 0, n_grant = 0;
  logic [31:0] exp_pc = 32'h0;
  bit halted = 0, err = 0;
  req_t infl[$];
  fetch_entry_t vis[$];
  logic [31:0] acc_addr[$], acc_inst[$];
  int acc_cyc[$];
  always #5 clk = ~clk;
  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_addr(inst_addr), .fetch_err(fetch_err)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // one clock: drive inputs, compare outputs with the model, advance the model across the edge
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit g, input bit rdy, input int rv_pct);
    bit exp_v, exp_req;
    logic [31:0] ea, ed;
    req_t e;
    int due;
    rst_n = r;
    redirect_valid = rd;
    redirect_pc = rpc;
    imem_gnt = g;
    inst_ready = rdy;
    imem_rvalid = infl.size() != 0 && infl[0].due <= cyc && int'($urandom_range(99)) < rv_pct;
    imem_rdata = imem_rvalid ? mem_word(infl[0].addr) : $urandom;
    #1;
    exp_v = vis.size() != 0;
    ea = exp_v ? vis[0].addr : 32'h0;
    ed = exp_v ? vis[0].inst : 32'h0;
    exp_req = r && entries < DEPTH && !rd && !halted;
    check("inst_valid", 32'(inst_valid), 32'(exp_v));
    check("inst_addr", inst_addr, ea);
    check("inst", inst, ed);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (!halted) check("imem_addr", imem_addr, exp_pc);
    check("fetch_err", 32'(fetch_err), 32'(err));
    if (imem_req && g) n_grant++;
    if (!r) begin
      infl.delete();
      vis.delete();
      entries = 0;
      exp_pc = 32'h0;
      halted = 0;
      err = 0;
    end else if (rd) begin
      if (imem_rvalid) e = infl.pop_front();
      foreach (infl[i]) infl[i].stale = 1;
      vis.delete();
      entries = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) begin
        err = 1;
        halted = 1;
      end
      exp_pc = rpc;
`else
      exp_pc = {rpc[31:2], 2'b00};
`endif
    end else begin
      if (exp_v && rdy) begin
        acc_addr.push_back(inst_addr);
        acc_inst.push_back(inst);
        acc_cyc.push_back(cyc);
        void'(vis.pop_front());
        entries--;
      end
      if (imem_rvalid) begin
        e = infl.pop_front();
        if (!e.stale) vis.push_back('{addr: e.addr, inst: mem_word(e.addr)});
      end
      if (exp_req && g) begin
        due = cyc + lat;
        if (infl.size() != 0 && infl[$].due > due) due = infl[$].due;
        infl.push_back('{addr: exp_pc, due: due, stale: 0});
        entries++;
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic drain();
    repeat (6) step(1, 0, 32'h0, 0, 1, 100);
  endtask
  initial begin
    int k;
    bit found;
    logic [31:0] p0, pc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    repeat (2) step(0, 0, 32'h0, 1, 1, 100);
    lat = 1;
    repeat (10) step(1, 0, 32'h0, 1, 1, 100);
    check("first_addr0", acc_addr[0], 32'h0);
    check("first_inst0", acc_inst[0], 32'h0000_0013);
    check("first_addr1", acc_addr[1], 32'h4);
    check("first_inst1", acc_inst[1], 32'h0010_0093);
    check("first_back2back", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    drain();
    n_grant = 0;
    p0 = exp_pc;
    repeat (12) step(1, 0, 32'h0, 1, 0, 100);
    check("stall_grants", 32'(n_grant), 32'(DEPTH));
    check("stall_req", 32'(imem_req), 32'd0);
    k = acc_addr.size();
    repeat (8) step(1, 0, 32'h0, 1, 1, 100);
    for (int i = 0; i < 4; i++) check("stall_drain", acc_addr[k+i], p0 + 32'(4 * i));
    drain();
    lat = 3;
    repeat (2) step(1, 0, 32'h0, 1, 0, 100);
    step(1, 1, 32'h100, 1, 0, 100);
    check("redir_addr", imem_addr, 32'h100);
    lat = 1;
    k = acc_addr.size();
    repeat (12) step(1, 0, 32'h0, 1, 1, 100);
    check("redir_first", acc_addr[k], 32'h100);
    check("redir_inst", acc_inst[k], mem_word(32'h100));
    lat = 2;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (vis.size() != 0 && infl.size() != 0 && infl[0].due <= cyc) found = 1;
      else step(1, 0, 32'h0, 1, 1, 100);
    end
    check("rv_redir_setup", 32'(found), 32'd1);
    step(1, 1, 32'h200, 1, 1, 100);
    k = acc_addr.size();
    repeat (12) step(1, 0, 32'h0, 1, 1, 100);
    check("rv_redir_first", acc_addr[k], 32'h200);
    lat = 1;
    drain();
    step(1, 1, 32'hFFFF_FFFC, 0, 1, 100);
    repeat (3) step(1, 0, 32'h0, 0, 1, 100);
    check("hold_addr", imem_addr, 32'hFFFF_FFFC);
    check("hold_req", 32'(imem_req), 32'd1);
    step(1, 0, 32'h0, 1, 1, 100);
    check("wrap_addr", imem_addr, 32'h0);
    repeat (8) step(1, 0, 32'h0, 1, 1, 100);
    k = acc_addr.size();
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
`ifndef FETCH_MISALIGN_CHECK_EN
      pc[1:0] = 2'($urandom_range(3));
`endif
      step(i != 1500, $urandom_range(99) < 3, pc, $urandom_range(99) < 75, $urandom_range(99) < 70, 80);
    end
    check("rand_progress", 32'(acc_addr.size() - k > 300), 32'd1);
    lat = 1;
    drain();
    step(1, 1, 32'h102, 1, 1, 100);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_err", 32'(fetch_err), 32'd1);
    repeat (3) step(1, 0, 32'h0, 1, 1, 100);
    check("misalign_halt", 32'(imem_req), 32'd0);
`else
    check("misalign_addr", imem_addr, 32'h100);
    k = acc_addr.size();
    repeat (6) step(1, 0, 32'h0, 1, 1, 100);
    check("misalign_first", acc_addr[k], 32'h100);
    check("misalign_err", 32'(fetch_err), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
